// File: rtl/usb_crc_checker.sv
// USB CRC checker: accumulates a packet one byte per clock and pulses pass/fail one cycle after eop.
// Optional USB_CRC_STICKY_ERR_EN adds a sticky error flag (err_sticky) cleared by clr_err.
module usb_crc_checker #(
   parameter int                 CRC_W   = 16,
   parameter logic [CRC_W-1:0]   POLY    = 16'h8005,
   parameter logic [CRC_W-1:0]   RESIDUE = 16'h800D,
   parameter int                 CNT_W   = 11
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [7:0]       data_in,
   input  logic             data_valid,
   input  logic             eop,
   output logic             busy,
   output logic             crc_valid,
   output logic             crc_err,
   output logic [CNT_W-1:0] byte_cnt
`ifdef USB_CRC_STICKY_ERR_EN
   ,
   input  logic             clr_err,
   output logic             err_sticky
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CRC_W-1:0] CRC_SEED = '1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [CRC_W-1:0] crc;

   logic             accept;
   logic [CRC_W-1:0] crc_seed_sel;
   logic [CNT_W-1:0] cnt_base;
   logic [CRC_W-1:0] crc_next;
   logic [CNT_W-1:0] cnt_next;
   logic             pass_next;

   function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                 input logic [7:0]       d);
      logic [CRC_W-1:0] c;
      logic             fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = d[i] ^ c[CRC_W-1];
         c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   // A start pulse reseeds the datapath in the same cycle, so a byte arriving alongside start is counted from zero.
   always_comb begin
      accept       = data_valid && (start || (state == ACCUM));
      crc_seed_sel = start ? CRC_SEED : crc;
      cnt_base     = start ? '0 : byte_cnt;
      crc_next     = accept ? crc_byte(crc_seed_sel, data_in) : crc_seed_sel;
      cnt_next     = cnt_base;
      if (accept && (cnt_base != CNT_MAX)) begin
         cnt_next = cnt_base + CNT_ONE;
      end
      pass_next    = (crc_next == RESIDUE) && (cnt_next != '0);
   end

   // The verdict is computed on the eop edge from the post-update values, so the pulse lands in the DONE cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         crc       <= CRC_SEED;
         byte_cnt  <= '0;
         busy      <= 1'b0;
         crc_valid <= 1'b0;
         crc_err   <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         crc_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  busy     <= 1'b1;
                  crc      <= crc_next;
                  byte_cnt <= cnt_next;
               end
            end
            ACCUM: begin
               crc      <= crc_next;
               byte_cnt <= cnt_next;
               if (!start && eop) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  crc_valid <= pass_next;
                  crc_err   <= !pass_next;
               end
            end
            DONE: begin
               if (start) begin
                  state    <= ACCUM;
                  busy     <= 1'b1;
                  crc      <= crc_next;
                  byte_cnt <= cnt_next;
               end else begin
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef USB_CRC_STICKY_ERR_EN
   // An error pulse takes priority over a coincident clear.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_sticky <= 1'b0;
      end else if (crc_err) begin
         err_sticky <= 1'b1;
      end else if (clr_err) begin
         err_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_usb_crc_checker.sv
// Self-checking bench for usb_crc_checker: a 16-bit and a 5-bit instance share one stimulus stream
// and are compared against a bit-serial reference model of each packet.
module tb_usb_crc_checker;

   logic        clk;
   logic        n_rst;
   logic        start;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        eop;

   logic        busy16, crc_valid16, crc_err16;
   logic [10:0] byte_cnt16;
   logic        busy5, crc_valid5, crc_err5;
   logic [2:0]  byte_cnt5;
`ifdef USB_CRC_STICKY_ERR_EN
   logic        clr_err;
   logic        err_sticky16, err_sticky5;
   logic        exp_sticky16, exp_sticky5;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] pkt[$];
   logic       exp_pass16, exp_pass5;
   int         exp_cnt16, exp_cnt5;

   usb_crc_checker #(.CRC_W(16), .POLY(16'h8005), .RESIDUE(16'h800D), .CNT_W(11)) u16 (
      .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in), .data_valid(data_valid),
      .eop(eop), .busy(busy16), .crc_valid(crc_valid16), .crc_err(crc_err16), .byte_cnt(byte_cnt16)
`ifdef USB_CRC_STICKY_ERR_EN
      , .clr_err(clr_err), .err_sticky(err_sticky16)
`endif
   );

   usb_crc_checker #(.CRC_W(5), .POLY(5'b00101), .RESIDUE(5'b01100), .CNT_W(3)) u5 (
      .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in), .data_valid(data_valid),
      .eop(eop), .busy(busy5), .crc_valid(crc_valid5), .crc_err(crc_err5), .byte_cnt(byte_cnt5)
`ifdef USB_CRC_STICKY_ERR_EN
      , .clr_err(clr_err), .err_sticky(err_sticky5)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Remainder of the whole packet, bits taken LSB first per byte, seed all ones.
   function automatic int ref_crc(input int w, input int poly);
      int mask;
      int c;
      int fb;
      mask = (1 << w) - 1;
      c    = mask;
      foreach (pkt[k]) begin
         for (int i = 0; i < 8; i++) begin
            fb = int'(pkt[k][i]) ^ ((c >> (w - 1)) & 1);
            c  = ((c << 1) & mask) ^ (fb != 0 ? poly : 0);
         end
      end
      return c;
   endfunction

   function automatic void build_expect();
      int n;
      n          = pkt.size();
      exp_pass16 = (ref_crc(16, 'h8005) == 'h800D) && (n != 0);
      exp_pass5  = (ref_crc(5, 'h05) == 'h0C) && (n != 0);
      exp_cnt16  = (n > 2047) ? 2047 : n;
      exp_cnt5   = (n > 7) ? 7 : n;
   endfunction

   // Append the inverted CRC16 of the current payload, high register bit first on the wire.
   function automatic void append_good_crc16();
      int c;
      logic [15:0] inv;
      logic [7:0]  b0, b1;
      c   = ref_crc(16, 'h8005);
      inv = ~c[15:0];
      for (int i = 0; i < 8; i++) begin
         b0[i] = inv[15 - i];
         b1[i] = inv[7 - i];
      end
      pkt.push_back(b0);
      pkt.push_back(b1);
   endfunction

   task automatic applyStimulus(input logic s, input logic dv, input logic [7:0] d, input logic e);
      start      = s;
      data_valid = dv;
      data_in    = d;
      eop        = e;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleQuiet(input string tag);
      checkOutput({tag, " busy16"}, 16'(busy16), 16'd0);
      checkOutput({tag, " pulses16"}, {14'd0, crc_valid16, crc_err16}, 16'd0);
      checkOutput({tag, " pulses5"}, {14'd0, crc_valid5, crc_err5}, 16'd0);
   endtask

   // Check the DONE-cycle verdict, then the following cycle (optionally a new start).
   task automatic checkResult(input string tag, input logic start_after);
      build_expect();
      checkOutput({tag, " valid16"}, 16'(crc_valid16), 16'(exp_pass16));
      checkOutput({tag, " err16"}, 16'(crc_err16), 16'(!exp_pass16));
      checkOutput({tag, " cnt16"}, 16'(byte_cnt16), 16'(exp_cnt16));
      checkOutput({tag, " valid5"}, 16'(crc_valid5), 16'(exp_pass5));
      checkOutput({tag, " err5"}, 16'(crc_err5), 16'(!exp_pass5));
      checkOutput({tag, " cnt5"}, 16'(byte_cnt5), 16'(exp_cnt5));
      checkOutput({tag, " busy_done"}, {14'd0, busy16, busy5}, 16'd0);
`ifdef USB_CRC_STICKY_ERR_EN
      exp_sticky16 = exp_sticky16 | !exp_pass16;
      exp_sticky5  = exp_sticky5 | !exp_pass5;
`endif
      applyStimulus(start_after, 1'b0, 8'h00, 1'b0);
      checkOutput({tag, " after_pulses"}, {12'd0, crc_valid16, crc_err16, crc_valid5, crc_err5}, 16'd0);
      if (start_after) begin
         checkOutput({tag, " restart_busy"}, {14'd0, busy16, busy5}, 16'h3);
         checkOutput({tag, " restart_cnt16"}, 16'(byte_cnt16), 16'd0);
      end else begin
         checkOutput({tag, " hold_cnt16"}, 16'(byte_cnt16), 16'(exp_cnt16));
         checkOutput({tag, " hold_cnt5"}, 16'(byte_cnt5), 16'(exp_cnt5));
         checkOutput({tag, " idle_busy"}, {14'd0, busy16, busy5}, 16'd0);
      end
`ifdef USB_CRC_STICKY_ERR_EN
      checkOutput({tag, " sticky16"}, 16'(err_sticky16), 16'(exp_sticky16));
      checkOutput({tag, " sticky5"}, 16'(err_sticky5), 16'(exp_sticky5));
`endif
   endtask

   task automatic runPacket(input string tag, input logic eop_last, input logic start_after);
      int n;
      n = pkt.size();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput({tag, " busy_accum"}, {14'd0, busy16, busy5}, 16'h3);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'b1, pkt[k], eop_last && (k == n - 1));
      end
      if (!eop_last || n == 0) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      end
      checkResult(tag, start_after);
   endtask

   initial begin
      n_rst      = 1'b0;
      start      = 1'b0;
      data_in    = 8'h00;
      data_valid = 1'b0;
      eop        = 1'b0;
`ifdef USB_CRC_STICKY_ERR_EN
      clr_err      = 1'b0;
      exp_sticky16 = 1'b0;
      exp_sticky5  = 1'b0;
`endif
      #3;
      checkIdleQuiet("reset");
      checkOutput("reset cnt", {5'd0, byte_cnt16}, 16'd0);
      checkOutput("reset cnt5", 16'(byte_cnt5), 16'd0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Data and eop while idle are ignored.
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkIdleQuiet("idle_ignore");
      checkOutput("idle_ignore cnt16", 16'(byte_cnt16), 16'd0);

      pkt = '{8'h00, 8'h10};
      runPacket("crc5_good", 1'b0, 1'b0);
      pkt = '{8'h00, 8'h18};
      runPacket("crc5_bad", 1'b0, 1'b0);
      pkt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hF7, 8'h5E};
      runPacket("crc16_vec", 1'b1, 1'b0);
      pkt = '{8'h00, 8'h00};
      runPacket("crc16_zero", 1'b0, 1'b0);
      pkt.delete();
      runPacket("empty", 1'b0, 1'b0);

      // Restart mid-packet with a coincident byte; only the bytes after the restart count.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h66, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
      checkOutput("restart cnt16", 16'(byte_cnt16), 16'd1);
      checkOutput("restart pulses", {14'd0, crc_valid16, crc_err16}, 16'd0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      pkt = '{8'h00, 8'h00};
      checkResult("restart", 1'b0);

      // Start during DONE still yields the pulse and moves straight to ACCUM.
      pkt = '{8'h12, 8'h34, 8'h56};
      runPacket("start_in_done", 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      pkt.delete();
      checkResult("after_done_start", 1'b0);

      // Long packet saturates the 3-bit counter.
      pkt.delete();
      for (int k = 0; k < 10; k++) pkt.push_back(8'(k * 17));
      append_good_crc16();
      runPacket("saturate", 1'b1, 1'b0);

      // Reset mid-packet discards it.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
      start      = 1'b0;
      data_valid = 1'b0;
      n_rst      = 1'b0;
      #2;
      checkIdleQuiet("midreset");
      checkOutput("midreset cnt16", 16'(byte_cnt16), 16'd0);
      n_rst = 1'b1;
`ifdef USB_CRC_STICKY_ERR_EN
      exp_sticky16 = 1'b0;
      exp_sticky5  = 1'b0;
`endif
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkIdleQuiet("midreset_eop");
      checkOutput("midreset_eop cnt16", 16'(byte_cnt16), 16'd0);

      // Random packets, roughly half carrying a valid CRC16 field.
      for (int p = 0; p < 24; p++) begin
         int len;
         pkt.delete();
         len = $urandom_range(0, 9);
         for (int k = 0; k < len; k++) pkt.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) append_good_crc16();
         runPacket($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 1'b0);
      end

`ifdef USB_CRC_STICKY_ERR_EN
      // Sticky flag survives a passing packet and drops only on clr_err.
      pkt = '{8'h00, 8'h18};
      runPacket("sticky_fail", 1'b0, 1'b0);
      pkt = '{8'h00, 8'h00};
      runPacket("sticky_pass", 1'b0, 1'b0);
      checkOutput("sticky hold16", 16'(err_sticky16), 16'd1);
      clr_err = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      clr_err = 1'b0;
      exp_sticky16 = 1'b0;
      exp_sticky5  = 1'b0;
      checkOutput("sticky clr16", 16'(err_sticky16), 16'd0);
      checkOutput("sticky clr5", 16'(err_sticky5), 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
